sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Parametrised CMD-line engine for the SD host: serialises a 48-bit SD command (start, direction, index, argument, CRC7, end bit), then optionally captures a 48-bit or 136-bit card response with CRC7, index and end-bit checking and a bit-period timeout. It generates the SD bus clock from the system clock. It reports completion, response and error status to the register block through level-held valid/ack handshakes. It replaces the fixed-function command path in the host top level and feeds the 010h response, 030h command-complete and 032h error bits [3:0].

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SD bit period; even, ≥2.
- TIMEOUT_BITS, 64: SD bit periods allowed between the command end bit and the response start bit.
- TO_W, 8: timeout counter width; must hold TIMEOUT_BITS.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- new_command  in  1  start request; one-cycle pulse or level.
- cmd_argument  in  32  command argument.
- cmd_index  in  6  command index.
- resp_type  in  2  response type: 00 none, 01 136-bit, 10 48-bit, 11 48-bit (busy handled outside this block).
- index_check_en  in  1  enables the index check on 48-bit responses.
- crc_check_en  in  1  enables the response CRC7 check.
- timeout_enable  in  1  enables the response timeout.
- cmd_pin_in  in  1  sampled CMD line.
- cmd_pin_out  out  1  driven CMD value.
- cmd_oe  out  1  CMD output enable.
- sd_clk  out  1  SD bus clock.
- busy  out  1  command inhibit (CMD).
- response  out  128  captured response.
- resp_valid  out  1  response available; held until resp_ack.
- resp_ack  in  1  clears resp_valid.
- cmd_complete  out  1  command finished; held until cmd_complete_ack.
- cmd_complete_ack  in  1  clears cmd_complete.
- err_status  out  4  {index_err, end_bit_err, crc_err, timeout_err}, matching 032h bits [3:0].

## Operation
- Divider: div_cnt runs free from 0 to CLK_DIV-1.
  - sd_clk = 0 while div_cnt < CLK_DIV/2, otherwise 1.
  - Drive strobe at div_cnt==0; sample strobe at div_cnt==CLK_DIV/2.
- States: IDLE → SEND → WAIT_START → RECV → DONE → IDLE.
- IDLE:
  - new_command is accepted only in IDLE.
  - On acceptance: load the 48-bit frame {0,1,cmd_index,cmd_argument,CRC7,1}; clear cmd_complete, resp_valid, err_status and response; set busy.
- SEND:
  - cmd_oe=1. One frame bit per drive strobe, MSB first.
  - CRC7 (poly x^7+x^3+1, init 0) is computed serially over the first 40 bits and inserted as bits 7:1.
  - After the end bit, at the next drive strobe: cmd_oe=0. If resp_type==00 go to DONE, else go to WAIT_START with the timeout counter at 0.
- WAIT_START:
  - Each sample strobe with cmd_pin_in=1 increments the counter.
  - When timeout_enable=1 and the counter reaches TIMEOUT_BITS: set timeout_err and go to DONE.
  - A sample of 0 is the start bit: go to RECV.
- RECV:
  - Shift in the remaining 47 bits (48-bit response) or 135 bits (136-bit response) on sample strobes.
  - CRC7 covers bits [47:8] for 48-bit responses and bits [127:8] for 136-bit responses.
- Checks, evaluated at entry to DONE:
  - crc_err: CRC enabled and received bits [7:1] ≠ computed CRC.
  - end_bit_err: bit0 ≠ 1.
  - index_err: 48-bit response, check enabled, and bits [45:40] ≠ cmd_index.
- Response mapping:
  - 48-bit: response[31:0] = bits [39:8], upper bits 0.
  - 136-bit: response[119:0] = bits [127:8], response[127:120] = 0.
- DONE:
  - Set cmd_complete.
  - Set resp_valid if resp_type≠00 and no timeout (errors do not suppress it).
  - Clear busy; go to IDLE.

## Timing
- Reset values: cmd_pin_out=1, cmd_oe=0, sd_clk=0, div_cnt=0, busy=0, response=0, resp_valid=0, cmd_complete=0, err_status=0, state IDLE.
- Reset mid-operation aborts immediately into the reset state; no completion is reported.
- busy rises in the cycle after acceptance.
- The first frame bit is driven at the first drive strobe after acceptance.
- No-response command: cmd_complete rises one clock after the drive strobe that follows the end bit.
- With a response: cmd_complete, resp_valid and err_status update in the same cycle, one clock after the sample strobe of the response end bit.
- Ack and set in the same cycle: set wins. Ack while the flag is low is ignored.
- new_command while busy: ignored, with no queuing.
- timeout_enable=0 means WAIT_START waits indefinitely; the counter saturates and does not wrap.

## Structure
- Package sd_host_pkg holds:
  - resp_type encodings (RESP_NONE, RESP_136, RESP_48, RESP_48B);
  - the state enumeration;
  - err_status bit positions;
  - CRC7 polynomial constant 7'h09.
- Sub-module sd_crc7: serial CRC7 with clear, enable and data-bit inputs and a 7-bit output. Two instances: transmit and receive.

## Test plan
- CMD0, arg 0, resp_type 00 → cmd_pin_out carries 0x40_00000000_95 over 48 drive strobes; cmd_complete=1, resp_valid=0, err_status=0.
- CMD8, arg 0x000001AA, resp_type 10, checks on, card replies 0x08_000001AA_13 → frame 0x48_000001AA_87; response=0x000001AA, resp_valid=1, err_status=0.
- Same as CMD8 with the reply index changed to 0x09 → index_err; reply CRC byte 0x15 → crc_err; reply end bit 0 → end_bit_err; each with cmd_complete=1.
- resp_type 10, timeout_enable=1, line held high → after 64 sample strobes err_status=4'b0001, cmd_complete=1, resp_valid=0.
- resp_type 01, bench-generated CID with valid CRC → response[119:0] = CID bits [127:8], response[127:120] = 0, no error.
- Three cases:
  - reset asserted mid-SEND → reset values on the next clock, cmd_oe=0;
  - new_command during busy → ignored;
  - cmd_complete_ack in the same cycle as completion → cmd_complete stays 1.

Source files
------------

// File: rtl/sd_host_pkg.sv
// Shared types and constants for the SD host CMD-line engine.
package sd_host_pkg;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_136  = 2'b01;
  localparam logic [1:0] RESP_48   = 2'b10;
  localparam logic [1:0] RESP_48B  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitStart,
    StRecv,
    StDone
  } cmd_state_e;

  // err_status bit positions, matching the 032h register layout
  localparam int unsigned ErrTimeout = 0;
  localparam int unsigned ErrCrc     = 1;
  localparam int unsigned ErrEndBit  = 2;
  localparam int unsigned ErrIndex   = 3;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_step(logic [6:0] crc, logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Register-block and CMD-pin signals of the SD command engine.
interface sd_cmd_engine_if;

  logic         new_command;
  logic [31:0]  cmd_argument;
  logic [5:0]   cmd_index;
  logic [1:0]   resp_type;
  logic         index_check_en;
  logic         crc_check_en;
  logic         timeout_enable;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         sd_clk;
  logic         busy;
  logic [127:0] response;
  logic         resp_valid;
  logic         resp_ack;
  logic         cmd_complete;
  logic         cmd_complete_ack;
  logic [3:0]   err_status;

  modport slave (
    input  new_command, cmd_argument, cmd_index, resp_type, index_check_en, crc_check_en,
           timeout_enable, cmd_pin_in, resp_ack, cmd_complete_ack,
    output cmd_pin_out, cmd_oe, sd_clk, busy, response, resp_valid, cmd_complete, err_status
  );

  modport master (
    output new_command, cmd_argument, cmd_index, resp_type, index_check_en, crc_check_en,
           timeout_enable, cmd_pin_in, resp_ack, cmd_complete_ack,
    input  cmd_pin_out, cmd_oe, sd_clk, busy, response, resp_valid, cmd_complete, err_status
  );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one data bit per enabled clock.
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= 7'h00;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command frame and optionally receives and
// checks a 48/136-bit response, with the SD bus clock derived from clock.
module sd_cmd_engine
  import sd_host_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned TIMEOUT_BITS = 64,
  parameter int unsigned TO_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  sd_cmd_engine_if.slave   bus
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_q;
  logic             drive_stb, samp_stb;

  always_ff @(posedge clock) begin
    if (reset || (div_cnt_q == DIV_W'(CLK_DIV - 1))) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  assign drive_stb = (div_cnt_q == '0);
  assign samp_stb  = (div_cnt_q == DIV_W'(HALF));

  cmd_state_e   state_q, state_d;
  logic [39:0]  tx_sh_q, tx_sh_d;
  logic [5:0]   tx_cnt_q, tx_cnt_d;
  logic [126:0] rx_q, rx_d;
  logic [7:0]   rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]   cmd_index_q, cmd_index_d;
  logic [1:0]   resp_type_q, resp_type_d;
  logic         pin_q, pin_d;
  logic         oe_q, oe_d;
  logic         busy_q, busy_d;
  logic [127:0] response_q, response_d;
  logic         resp_valid_q, resp_valid_d;
  logic         complete_q, complete_d;
  logic [3:0]   err_q, err_d;

  logic         tx_crc_en, rx_crc_en, crc_clr;
  logic [6:0]   tx_crc, rx_crc;
  logic         is48;
  logic [7:0]   rx_last, crc_lo, crc_hi;
  logic [TO_W:0] to_inc;

  sd_crc7 u_tx_crc (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (crc_clr),
    .en_i  (tx_crc_en),
    .bit_i (tx_sh_q[39]),
    .crc_o (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (crc_clr),
    .en_i  (rx_crc_en),
    .bit_i (bus.cmd_pin_in),
    .crc_o (rx_crc)
  );

  assign is48    = (resp_type_q != RESP_136);
  assign rx_last = is48 ? 8'd47 : 8'd135;
  // CRC window counted in received-bit order, start bit being 0
  assign crc_lo  = is48 ? 8'd0  : 8'd8;
  assign crc_hi  = is48 ? 8'd39 : 8'd127;
  assign to_inc  = {1'b0, to_cnt_q} + 1'b1;

  always_comb begin
    state_d      = state_q;
    tx_sh_d      = tx_sh_q;
    tx_cnt_d     = tx_cnt_q;
    rx_d         = rx_q;
    rx_cnt_d     = rx_cnt_q;
    to_cnt_d     = to_cnt_q;
    cmd_index_d  = cmd_index_q;
    resp_type_d  = resp_type_q;
    pin_d        = pin_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    response_d   = response_q;
    resp_valid_d = resp_valid_q;
    complete_d   = complete_q;
    err_d        = err_q;
    tx_crc_en    = 1'b0;
    rx_crc_en    = 1'b0;
    crc_clr      = 1'b0;

    // Acks are applied first so that a set later in this process wins.
    if (bus.cmd_complete_ack) complete_d   = 1'b0;
    if (bus.resp_ack)         resp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.new_command) begin
          tx_sh_d      = {1'b0, 1'b1, bus.cmd_index, bus.cmd_argument};
          tx_cnt_d     = '0;
          cmd_index_d  = bus.cmd_index;
          resp_type_d  = bus.resp_type;
          complete_d   = 1'b0;
          resp_valid_d = 1'b0;
          err_d        = '0;
          response_d   = '0;
          busy_d       = 1'b1;
          crc_clr      = 1'b1;
          state_d      = StSend;
        end
      end

      StSend: begin
        if (drive_stb) begin
          if (tx_cnt_q < 6'd48) begin
            oe_d     = 1'b1;
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_cnt_q < 6'd40) begin
              pin_d     = tx_sh_q[39];
              tx_sh_d   = {tx_sh_q[38:0], 1'b0};
              tx_crc_en = 1'b1;
            end else if (tx_cnt_q < 6'd47) begin
              // 40 is a multiple of 8, so the low bits step the CRC from MSB down
              pin_d = tx_crc[3'd6 - tx_cnt_q[2:0]];
            end else begin
              pin_d = 1'b1;
            end
          end else begin
            oe_d  = 1'b0;
            pin_d = 1'b1;
            if (resp_type_q == RESP_NONE) begin
              complete_d = 1'b1;
              state_d    = StDone;
            end else begin
              to_cnt_d = '0;
              state_d  = StWaitStart;
            end
          end
        end
      end

      StWaitStart: begin
        if (samp_stb) begin
          if (!bus.cmd_pin_in) begin
            rx_d      = '0;
            rx_cnt_d  = 8'd1;
            rx_crc_en = is48;
            state_d   = StRecv;
          end else begin
            to_cnt_d = to_inc[TO_W] ? to_cnt_q : to_inc[TO_W-1:0];
            if (bus.timeout_enable && (to_inc >= (TO_W + 1)'(TIMEOUT_BITS))) begin
              err_d[ErrTimeout] = 1'b1;
              complete_d        = 1'b1;
              state_d           = StDone;
            end
          end
        end
      end

      StRecv: begin
        if (samp_stb) begin
          rx_d      = {rx_q[125:0], bus.cmd_pin_in};
          rx_cnt_d  = rx_cnt_q + 1'b1;
          rx_crc_en = (rx_cnt_q >= crc_lo) && (rx_cnt_q <= crc_hi);
          if (rx_cnt_q == rx_last) begin
            // rx_q[k] holds response bit k+1; the end bit is still on the pin
            err_d[ErrCrc]    = bus.crc_check_en && (rx_q[6:0] != rx_crc);
            err_d[ErrEndBit] = !bus.cmd_pin_in;
            err_d[ErrIndex]  = is48 && bus.index_check_en && (rx_q[44:39] != cmd_index_q);
            response_d       = is48 ? {96'h0, rx_q[38:7]} : {8'h00, rx_q[126:7]};
            resp_valid_d     = 1'b1;
            complete_d       = 1'b1;
            state_d          = StDone;
          end
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      tx_sh_q      <= '0;
      tx_cnt_q     <= '0;
      rx_q         <= '0;
      rx_cnt_q     <= '0;
      to_cnt_q     <= '0;
      cmd_index_q  <= '0;
      resp_type_q  <= RESP_NONE;
      pin_q        <= 1'b1;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      response_q   <= '0;
      resp_valid_q <= 1'b0;
      complete_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_sh_q      <= tx_sh_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_q         <= rx_d;
      rx_cnt_q     <= rx_cnt_d;
      to_cnt_q     <= to_cnt_d;
      cmd_index_q  <= cmd_index_d;
      resp_type_q  <= resp_type_d;
      pin_q        <= pin_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      response_q   <= response_d;
      resp_valid_q <= resp_valid_d;
      complete_q   <= complete_d;
      err_q        <= err_d;
    end
  end

  assign bus.sd_clk       = (div_cnt_q >= DIV_W'(HALF));
  assign bus.cmd_pin_out  = pin_q;
  assign bus.cmd_oe       = oe_q;
  assign bus.busy         = busy_q;
  assign bus.response     = response_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.cmd_complete = complete_q;
  assign bus.err_status   = err_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine with a simple card model on the CMD line.
module tb_sd_cmd_engine;
  import sd_host_pkg::*;

  localparam int unsigned CLK_DIV      = 4;
  localparam int unsigned TIMEOUT_BITS = 64;

  typedef struct {
    string        tag;
    logic [47:0]  frame;
    logic         rv;
    logic [127:0] resp;
    logic [3:0]   err;
    int           to_rises;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rose, fell;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  sd_cmd_engine_if bus ();

  sd_cmd_engine #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .TO_W         (8)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic p;
    p = bus.sd_clk;
    @(posedge clock);
    #1;
    rose = !p && bus.sd_clk;
    fell = p && !bus.sd_clk;
  endtask

  task automatic wait_fall();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!fell && t < 4 * CLK_DIV);
    if (!fell) check_eq("sd_clk_fall_timeout", 0, 1);
  endtask

  function automatic logic [6:0] crc7_calc(input logic [127:0] data, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make48(input logic [1:0] hdr, input logic [5:0] idx,
                                         input logic [31:0] arg);
    logic [39:0] body;
    body = {hdr, idx, arg};
    return {body, crc7_calc({88'h0, body}, 40), 1'b1};
  endfunction

  task automatic push_exp(input string tag, input logic [47:0] frame, input logic rv,
                          input logic [127:0] resp, input logic [3:0] err, input int to_rises);
    exp_t e;
    e.tag = tag; e.frame = frame; e.rv = rv; e.resp = resp; e.err = err;
    e.to_rises = to_rises;
    sb.push_back(e);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                         input logic [135:0] reply, input int rlen, input bit ack_race,
                         input bit poke);
    exp_t        e;
    logic [47:0] frame;
    int          n, rises;
    bit          poked;
    bus.cmd_index    = idx;
    bus.cmd_argument = arg;
    bus.resp_type    = rtype;
    bus.new_command  = 1'b1;
    tick();
    bus.new_command  = 1'b0;
    e = sb.pop_front();
    check_eq({e.tag, ":busy_rise"}, bus.busy, 1);
    n = 0; frame = '0; poked = 1'b0;
    for (int t = 0; t < 60 * CLK_DIV && n < 48; t++) begin
      bus.new_command = poke && (n == 10) && !poked;
      if (bus.new_command) begin
        bus.cmd_index = 6'h3F;
        poked = 1'b1;
      end
      tick();
      bus.new_command = 1'b0;
      if (rose && bus.cmd_oe) begin
        frame = {frame[46:0], bus.cmd_pin_out};
        n++;
      end
    end
    check_eq({e.tag, ":frame"}, frame, e.frame);
    wait_fall();
    if (ack_race) begin
      bus.cmd_complete_ack = 1'b1;
      tick();
      bus.cmd_complete_ack = 1'b0;
      check_eq({e.tag, ":ack_race"}, bus.cmd_complete, 1);
    end
    if (rlen > 0) begin
      wait_fall();
      for (int i = rlen - 1; i >= 0; i--) begin
        bus.cmd_pin_in = reply[i];
        wait_fall();
      end
      bus.cmd_pin_in = 1'b1;
    end
    rises = 0;
    for (int t = 0; t < (TIMEOUT_BITS + 8) * CLK_DIV && !bus.cmd_complete; t++) begin
      tick();
      if (rose) rises++;
    end
    if (e.to_rises >= 0) check_eq({e.tag, ":timeout_samples"}, rises, e.to_rises);
    check_eq({e.tag, ":complete"}, bus.cmd_complete, 1);
    check_eq({e.tag, ":resp_valid"}, bus.resp_valid, e.rv);
    check_eq({e.tag, ":response"}, bus.response, e.resp);
    check_eq({e.tag, ":err_status"}, bus.err_status, e.err);
    tick();
    check_eq({e.tag, ":busy_fall"}, bus.busy, 0);
    bus.cmd_complete_ack = 1'b1;
    bus.resp_ack         = 1'b1;
    tick();
    bus.cmd_complete_ack = 1'b0;
    bus.resp_ack         = 1'b0;
    check_eq({e.tag, ":complete_cleared"}, bus.cmd_complete, 0);
    check_eq({e.tag, ":resp_valid_cleared"}, bus.resp_valid, 0);
  endtask

  initial begin
    logic [119:0] cid;
    logic [135:0] r136;
    logic [47:0]  r48;
    int           n;

    bus.new_command = 1'b0; bus.cmd_argument = '0; bus.cmd_index = '0;
    bus.resp_type = RESP_NONE; bus.index_check_en = 1'b1; bus.crc_check_en = 1'b1;
    bus.timeout_enable = 1'b1; bus.cmd_pin_in = 1'b1;
    bus.resp_ack = 1'b0; bus.cmd_complete_ack = 1'b0;
    rose = 1'b0; fell = 1'b0;

    repeat (3) tick();
    check_eq("rst:cmd_pin_out", bus.cmd_pin_out, 1);
    check_eq("rst:cmd_oe", bus.cmd_oe, 0);
    check_eq("rst:sd_clk", bus.sd_clk, 0);
    check_eq("rst:busy", bus.busy, 0);
    check_eq("rst:response", bus.response, 0);
    check_eq("rst:resp_valid", bus.resp_valid, 0);
    check_eq("rst:cmd_complete", bus.cmd_complete, 0);
    check_eq("rst:err_status", bus.err_status, 0);
    reset = 1'b0;
    tick();

    push_exp("cmd0", 48'h40_0000_0000_95, 1'b0, '0, 4'b0000, -1);
    run_cmd(6'd0, 32'h0, RESP_NONE, '0, 0, 1'b0, 1'b0);

    push_exp("cmd8", 48'h48_0000_01AA_87, 1'b1, 128'h1AA, 4'b0000, -1);
    run_cmd(6'd8, 32'h1AA, RESP_48, {88'h0, 48'h08_0000_01AA_13}, 48, 1'b0, 1'b0);

    r48 = make48(2'b00, 6'h09, 32'h1AA);
    push_exp("cmd8_index_err", 48'h48_0000_01AA_87, 1'b1, 128'h1AA, 4'b1000, -1);
    run_cmd(6'd8, 32'h1AA, RESP_48, {88'h0, r48}, 48, 1'b0, 1'b0);

    push_exp("cmd8_crc_err", 48'h48_0000_01AA_87, 1'b1, 128'h1AA, 4'b0010, -1);
    run_cmd(6'd8, 32'h1AA, RESP_48, {88'h0, 48'h08_0000_01AA_15}, 48, 1'b0, 1'b0);

    push_exp("cmd8_end_err", 48'h48_0000_01AA_87, 1'b1, 128'h1AA, 4'b0100, -1);
    run_cmd(6'd8, 32'h1AA, RESP_48, {88'h0, 48'h08_0000_01AA_12}, 48, 1'b0, 1'b0);

    push_exp("timeout", make48(2'b01, 6'd17, 32'h1234_5678), 1'b0, '0, 4'b0001,
             int'(TIMEOUT_BITS));
    run_cmd(6'd17, 32'h1234_5678, RESP_48B, '0, 0, 1'b0, 1'b0);

    cid  = 120'h03_5344_5355_3136_4780_1234_5678_9A01;
    r136 = {8'h3F, cid, crc7_calc({8'h0, cid}, 120), 1'b1};
    push_exp("cmd2_cid", make48(2'b01, 6'd2, 32'h0), 1'b1, {8'h00, cid}, 4'b0000, -1);
    run_cmd(6'd2, 32'h0, RESP_136, r136, 136, 1'b0, 1'b0);

    push_exp("cmd0_ack_race", 48'h40_0000_0000_95, 1'b0, '0, 4'b0000, -1);
    run_cmd(6'd0, 32'h0, RESP_NONE, '0, 0, 1'b1, 1'b0);

    push_exp("busy_poke", make48(2'b01, 6'd13, 32'hCAFE_0001), 1'b0, '0, 4'b0000, -1);
    run_cmd(6'd13, 32'hCAFE_0001, RESP_NONE, '0, 0, 1'b0, 1'b1);
    repeat (60 * CLK_DIV) tick();
    check_eq("busy_poke:no_queue_complete", bus.cmd_complete, 0);
    check_eq("busy_poke:no_queue_busy", bus.busy, 0);

    // Abort a command partway through its frame.
    bus.cmd_index = 6'd0; bus.resp_type = RESP_NONE; bus.new_command = 1'b1;
    tick();
    bus.new_command = 1'b0;
    n = 0;
    for (int t = 0; t < 30 * CLK_DIV && n < 10; t++) begin
      tick();
      if (rose && bus.cmd_oe) n++;
    end
    check_eq("mid_send:oe_before_reset", bus.cmd_oe, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_send:cmd_oe", bus.cmd_oe, 0);
    check_eq("mid_send:cmd_pin_out", bus.cmd_pin_out, 1);
    check_eq("mid_send:busy", bus.busy, 0);
    check_eq("mid_send:sd_clk", bus.sd_clk, 0);
    repeat (60 * CLK_DIV) tick();
    check_eq("mid_send:no_complete", bus.cmd_complete, 0);
    check_eq("mid_send:oe_quiet", bus.cmd_oe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
